// File: rtl/fb_capture_ctrl.sv
// Purpose : frame-buffer write sequencer; frames a byte-serial RGB565 camera stream and clips it to the buffer geometry.
// Latency : port-A write appears one cycle after the second byte of a pixel is sampled; frame_done one cycle after vsync rises.
// Backpressure: none; the camera cannot be stalled and the buffer port always accepts a write.
module fb_capture_ctrl #(
    parameter int c_img_cols    = 80,
    parameter int c_img_rows    = 60,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_continuous,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic                     cam_pxl_en,
    input  logic [7:0]               cam_data,
    output logic                     fb_wea,
    output logic [c_nb_img_pxls-1:0] fb_addra,
    output logic [c_nb_buf-1:0]      fb_dina,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_short_frame
);

    // Counters need one code above the limit so they can saturate there.
    localparam int c_nb_col = $clog2(c_img_cols + 1);
    localparam int c_nb_row = $clog2(c_img_rows + 1);

    localparam logic [c_nb_col-1:0]      c_col_lim   = c_nb_col'(c_img_cols);
    localparam logic [c_nb_row-1:0]      c_row_lim   = c_nb_row'(c_img_rows);
    localparam logic [c_nb_img_pxls-1:0] c_line_step = c_nb_img_pxls'(c_img_cols);
    localparam logic [c_nb_img_pxls-1:0] c_addr_one  = c_nb_img_pxls'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Delayed copies of the camera framing signals for edge detection.
    logic r_href_d;
    logic r_vsync_d;

    // Capture position within the frame.
    logic [c_nb_col-1:0]      r_col;
    logic [c_nb_row-1:0]      r_row;
    logic [c_nb_img_pxls-1:0] r_addr;
    logic [c_nb_img_pxls-1:0] r_line_base;
    logic                     r_phase;
    logic [7:0]               r_hi_byte;

    // Registered outputs.
    logic                     r_wea;
    logic [c_nb_img_pxls-1:0] r_addra;
    logic [c_nb_buf-1:0]      r_dina;
    logic                     r_busy;
    logic                     r_frame_done;
    logic                     r_short_frame;

    // Decoded events and FSM-qualified strobes.
    logic w_href_fall;
    logic w_vsync_rise;
    logic w_pxl_stb;
    logic w_frame_init;
    logic w_frame_end;
    logic w_line_end;
    logic w_byte_stb;
    logic w_pxl_in_win;

    assign w_href_fall  = r_href_d & ~cam_href;
    assign w_vsync_rise = cam_vsync & ~r_vsync_d;
    assign w_pxl_stb    = cam_href & cam_pxl_en;
    assign w_pxl_in_win = (r_col < c_col_lim) && (r_row < c_row_lim);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state event strobes for the datapath.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_init = 1'b0;
        w_frame_end  = 1'b0;
        w_line_end   = 1'b0;
        w_byte_stb   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start || i_continuous) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                // Wait for the inter-frame gap so capture never starts mid-frame.
                if (cam_vsync) begin
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!cam_vsync) begin
                    w_state_nxt  = S_CAPTURE;
                    w_frame_init = 1'b1;
                end
            end
            S_CAPTURE: begin
                // vsync rising ends the frame even mid-line; a partial line is not counted.
                if (w_vsync_rise) begin
                    w_state_nxt = S_DONE;
                    w_frame_end = 1'b1;
                end else if (w_href_fall) begin
                    w_line_end = 1'b1;
                end else if (w_pxl_stb) begin
                    w_byte_stb = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = i_continuous ? S_SYNC : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample framing signals one cycle late for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_href_d  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_href_d  <= cam_href;
            r_vsync_d <= cam_vsync;
        end
    end

    // Column, row, byte phase and address tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            r_phase     <= 1'b0;
            r_hi_byte   <= '0;
        end else if (w_frame_init) begin
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            r_phase     <= 1'b0;
        end else if (w_frame_end) begin
            // Any odd byte still pending is simply forgotten.
            r_phase <= 1'b0;
        end else if (w_line_end) begin
            r_col   <= '0;
            r_phase <= 1'b0;
            // The next line base is kept by accumulation so no multiplier is needed.
            if ((r_col != '0) && (r_row < c_row_lim)) begin
                r_row       <= r_row + 1'b1;
                r_line_base <= r_line_base + c_line_step;
                r_addr      <= r_line_base + c_line_step;
            end else begin
                r_addr <= r_line_base;
            end
        end else if (w_byte_stb) begin
            if (!r_phase) begin
                r_hi_byte <= cam_data;
                r_phase   <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                if (w_pxl_in_win) begin
                    r_addr <= r_addr + c_addr_one;
                end
                if (r_col < c_col_lim) begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Buffer write port: one-cycle strobe per in-window pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else begin
            r_wea <= 1'b0;
            if (w_byte_stb && r_phase && w_pxl_in_win) begin
                r_wea   <= 1'b1;
                r_addra <= r_addr;
                r_dina  <= c_nb_buf'({r_hi_byte, cam_data});
            end
        end
    end

    // Status outputs: busy follows the next state, done pulses as DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_frame_end;
            if (w_frame_init) begin
                r_short_frame <= 1'b0;
            end else if (w_frame_end) begin
                r_short_frame <= (r_row < c_row_lim);
            end
        end
    end

    assign fb_wea        = r_wea;
    assign fb_addra      = r_addra;
    assign fb_dina       = r_dina;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_short_frame = r_short_frame;

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// Purpose : directed bench for fb_capture_ctrl with hand-computed expected writes.
// Latency : inputs driven 1 ns after the rising edge, outputs logged on the falling edge.
// Backpressure: not applicable.
module tb_fb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_continuous = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic        cam_pxl_en = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        fb_wea;
    logic [12:0] fb_addra;
    logic [15:0] fb_dina;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_short_frame;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt = 0;
    int busy_low = 0;
    logic watch_busy = 1'b0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [7:0]  line_q[$];

    always #5 clk = ~clk;

    fb_capture_ctrl #(
        .c_img_cols   (80),
        .c_img_rows   (60),
        .c_nb_img_pxls(13),
        .c_nb_buf     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_continuous (i_continuous),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_pxl_en   (cam_pxl_en),
        .cam_data     (cam_data),
        .fb_wea       (fb_wea),
        .fb_addra     (fb_addra),
        .fb_dina      (fb_dina),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_short_frame(o_short_frame)
    );

    // Log every buffer write and every frame_done cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (fb_wea) begin
                wr_addr.push_back(16'(fb_addra));
                wr_data.push_back(fb_dina);
            end
            if (o_frame_done) fd_cnt++;
            if (watch_busy && !o_busy) busy_low++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 16'hFFFF;
    endfunction

    function automatic logic [15:0] wd(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 16'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic frame_open();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_line();
        cam_href = 1'b1;
        tick();
        while (line_q.size() > 0) begin
            cam_pxl_en = 1'b1;
            cam_data   = line_q.pop_front();
            tick();
        end
        cam_pxl_en = 1'b0;
        cam_href   = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_close(input string tag);
        int prev;
        int got;
        prev = fd_cnt;
        got  = 0;
        cam_vsync = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (fd_cnt > prev) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev_fd;
        int bad;
        int maxa;

        // Reset values
        repeat (3) tick();
        chk("rst_wea",   32'(fb_wea), 32'd0);
        chk("rst_addr",  32'(fb_addra), 32'd0);
        chk("rst_dina",  32'(fb_dina), 32'd0);
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_done",  32'(o_frame_done), 32'd0);
        chk("rst_short", 32'(o_short_frame), 32'd0);
        rst = 1'b0;
        tick();

        // Reset during capture with a write on the port
        start_pulse();
        chk("start_busy", 32'(o_busy), 32'd1);
        frame_open();
        cam_href = 1'b1;
        cam_pxl_en = 1'b1;
        cam_data = 8'h55;
        tick();
        cam_data = 8'h66;
        tick();
        cam_pxl_en = 1'b0;
        chk("midrst_pre_wea", 32'(fb_wea), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_wea",   32'(fb_wea), 32'd0);
        chk("midrst_addr",  32'(fb_addra), 32'd0);
        chk("midrst_dina",  32'(fb_dina), 32'd0);
        chk("midrst_busy",  32'(o_busy), 32'd0);
        chk("midrst_done",  32'(o_frame_done), 32'd0);
        chk("midrst_short", 32'(o_short_frame), 32'd0);
        tick();
        rst = 1'b0;
        clear_log();
        prev_fd = fd_cnt;
        for (int i = 0; i < 6; i++) line_q.push_back(8'(i + 1));
        send_line();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) line_q.push_back(8'(i + 9));
        send_line();
        chk("postrst_writes", 32'(wr_addr.size()), 32'd0);
        chk("postrst_busy",   32'(o_busy), 32'd0);
        chk("postrst_done",   32'(fd_cnt - prev_fd), 32'd0);

        // Basic frame: two short lines
        clear_log();
        prev_fd = fd_cnt;
        start_pulse();
        frame_open();
        line_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_line();
        line_q = '{8'h11, 8'h22};
        send_line();
        frame_close("basic");
        chk("basic_short", 32'(o_short_frame), 32'd1);
        repeat (5) tick();
        chk("basic_nwr",   32'(wr_addr.size()), 32'd3);
        chk("basic_a0",    32'(wa(0)), 32'd0);
        chk("basic_d0",    32'(wd(0)), 32'hA1B2);
        chk("basic_a1",    32'(wa(1)), 32'd1);
        chk("basic_d1",    32'(wd(1)), 32'hC3D4);
        chk("basic_a2",    32'(wa(2)), 32'd80);
        chk("basic_d2",    32'(wd(2)), 32'h1122);
        chk("basic_pulse", 32'(fd_cnt - prev_fd), 32'd1);
        chk("basic_idle",  32'(o_busy), 32'd0);
        chk("basic_short_held", 32'(o_short_frame), 32'd1);

        // Line clip: 82 pixels then a one-pixel line
        clear_log();
        start_pulse();
        frame_open();
        for (int p = 0; p < 82; p++) begin
            line_q.push_back(8'(2 * p));
            line_q.push_back(8'(2 * p + 1));
        end
        send_line();
        line_q = '{8'hAA, 8'hBB};
        send_line();
        frame_close("lclip");
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (wa(i) != 16'(i) || wd(i) != {8'(2 * i), 8'(2 * i + 1)}) bad++;
        end
        chk("lclip_nwr",  32'(wr_addr.size()), 32'd81);
        chk("lclip_seq",  32'(bad), 32'd0);
        chk("lclip_a80",  32'(wa(80)), 32'd80);
        chk("lclip_d80",  32'(wd(80)), 32'hAABB);

        // Row clip: 62 full lines
        clear_log();
        start_pulse();
        frame_open();
        for (int l = 0; l < 62; l++) begin
            for (int p = 0; p < 80; p++) begin
                line_q.push_back(8'(l));
                line_q.push_back(8'(p));
            end
            send_line();
        end
        frame_close("rclip");
        repeat (3) tick();
        bad = 0;
        maxa = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != 16'(i) || wr_data[i] != {8'(i / 80), 8'(i % 80)}) bad++;
            if (int'(wr_addr[i]) > maxa) maxa = int'(wr_addr[i]);
        end
        chk("rclip_nwr",   32'(wr_addr.size()), 32'd4800);
        chk("rclip_seq",   32'(bad), 32'd0);
        chk("rclip_maxa",  32'(maxa), 32'd4799);
        chk("rclip_dlast", 32'(wd(4799)), 32'h3B4F);
        chk("rclip_short", 32'(o_short_frame), 32'd0);

        // Odd byte discarded at line end
        clear_log();
        start_pulse();
        frame_open();
        line_q = '{8'h01, 8'h02, 8'h03};
        send_line();
        line_q = '{8'h04, 8'h05};
        send_line();
        frame_close("odd");
        repeat (3) tick();
        chk("odd_nwr", 32'(wr_addr.size()), 32'd2);
        chk("odd_a0",  32'(wa(0)), 32'd0);
        chk("odd_d0",  32'(wd(0)), 32'h0102);
        chk("odd_a1",  32'(wa(1)), 32'd80);
        chk("odd_d1",  32'(wd(1)), 32'h0405);

        // Continuous: two frames without i_start
        clear_log();
        prev_fd = fd_cnt;
        busy_low = 0;
        i_continuous = 1'b1;
        frame_open();
        line_q = '{8'h10, 8'h20};
        send_line();
        frame_close("cont1");
        watch_busy = 1'b1;
        frame_open();
        line_q = '{8'h30, 8'h40};
        send_line();
        watch_busy = 1'b0;
        i_continuous = 1'b0;
        frame_close("cont2");
        repeat (5) tick();
        chk("cont_pulses",   32'(fd_cnt - prev_fd), 32'd2);
        chk("cont_busy_gap", 32'(busy_low), 32'd0);
        chk("cont_nwr",      32'(wr_addr.size()), 32'd2);
        chk("cont_a0",       32'(wa(0)), 32'd0);
        chk("cont_d0",       32'(wd(0)), 32'h1020);
        chk("cont_a1",       32'(wa(1)), 32'd0);
        chk("cont_d1",       32'(wd(1)), 32'h3040);
        chk("cont_idle",     32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_capture_ctrl.md
# fb_capture_ctrl

Write-side sequencer for the camera frame buffer. Takes the byte-serial RGB565 stream from the camera front end, already synchronised to `clk`. Frames each capture on `cam_vsync`/`cam_href` and pairs bytes into 16-bit pixels. Generates the buffer's port-A write strobe, address and data, clipping any frame larger than the buffer geometry; the display side reads port B independently.

## Interface

Parameters:

- `c_img_cols`, 80, pixels per stored line
- `c_img_rows`, 60, stored lines per frame
- `c_nb_img_pxls`, 13, address width; must satisfy 2^c_nb_img_pxls ≥ c_img_cols·c_img_rows
- `c_nb_buf`, 16, buffer word width; fixed at 16 for RGB565

Ports:

- `clk` in 1: system clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `i_start` in 1: one-cycle request to capture one frame; honoured only in IDLE
- `i_continuous` in 1: when high, capture frames back-to-back without `i_start`
- `cam_vsync` in 1: frame sync; high between frames
- `cam_href` in 1: line valid
- `cam_pxl_en` in 1: one-cycle strobe, `cam_data` valid
- `cam_data` in 8: pixel byte; first byte is the RGB565 high byte
- `fb_wea` out 1: buffer write enable
- `fb_addra` out c_nb_img_pxls: buffer write address
- `fb_dina` out c_nb_buf: buffer write data {byte0, byte1}
- `o_busy` out 1: high in any state other than IDLE
- `o_frame_done` out 1: one-cycle pulse when a frame ends
- `o_short_frame` out 1: set with `o_frame_done` if fewer than c_img_rows lines arrived; held until next frame start

## Operation

FSM states are IDLE, ARM, SYNC, CAPTURE and DONE.

- **IDLE**: if `i_start` or `i_continuous`, go to ARM.
- **ARM**: wait for `cam_vsync`=1, so that capture never starts mid-frame, then go to SYNC.
- **SYNC**: on `cam_vsync`=0, clear col, row, address and byte phase, clear `o_short_frame`, then go to CAPTURE.
- **CAPTURE**:
  - With `cam_href`=1 and `cam_pxl_en`=1:
    - Phase 0: latch the high byte.
    - Phase 1: form the pixel. If col < c_img_cols and row < c_img_rows, issue a write and advance the address. Increment col, saturating at c_img_cols.
  - A falling edge on `cam_href` (previous 1, current 0) does the following:
    - If col > 0, increment row, saturating at c_img_rows.
    - Set col to 0 and byte phase to 0.
    - Set address to row_next·c_img_cols, maintained by adding c_img_cols to a line-base register; no multiplier.
  - A rising edge on `cam_vsync` goes to DONE.
- **DONE**: pulse `o_frame_done` for one cycle and set `o_short_frame` if row < c_img_rows. Then go to SYNC if `i_continuous`, else IDLE.

Boundary rules:

- Excess pixels in a line and excess lines in a frame are dropped silently. The address never exceeds c_img_cols·c_img_rows−1.
- An odd byte left pending at a line or frame end is discarded; no write is issued.
- If `cam_pxl_en` and an `href` falling edge occur in the same cycle: `href` is already 0, so the byte is ignored and the line end is processed.
- A `vsync` rising edge while `href`=1 ends the frame. Any pending byte is discarded, and row is not incremented for the partial line.
- `i_start` outside IDLE is ignored. Dropping `i_continuous` mid-frame finishes the current frame, then returns to IDLE.
- `rst` asserted at any time returns to IDLE and clears all counters. No further writes are issued; buffer contents are untouched.

## Timing

- Reset values: `fb_wea`=0, `fb_addra`=0, `fb_dina`=0, `o_busy`=0, `o_frame_done`=0, `o_short_frame`=0.
- All outputs are registered.
- Write latency: `fb_wea`, `fb_addra` and `fb_dina` are valid in the cycle after the phase-1 `cam_pxl_en` sample. `fb_wea` is high for exactly one cycle per pixel.
- Edges are detected against 1-cycle-delayed copies of `cam_href`/`cam_vsync`. Action occurs on the first cycle the new level is sampled.
- `o_frame_done` is asserted the cycle after the `vsync` rising edge is detected.
- Minimum pixel strobe spacing is 1 cycle; back-to-back strobes every cycle are supported.
- `o_busy` rises the cycle after the IDLE exit condition and falls on the cycle IDLE is re-entered.

## Test plan

1. **Reset**: assert `rst` mid-CAPTURE with `fb_wea` pending → all outputs 0 the same cycle; no write after release until a new `i_start` and full vsync cycle.
2. **Basic frame**: `i_start`, vsync 1→0, line 0 bytes A1,B2,C3,D4 and line 1 bytes 11,22 (both lines ended by href fall), vsync 0→1 → writes addr0=A1B2, addr1=C3D4, addr80=1122; `o_frame_done` single pulse; `o_short_frame`=1; return to IDLE.
3. **Line clip**: one line of 82 pixels → writes addr 0..79 only; next line's first pixel at addr 80.
4. **Row clip**: 62 full lines → last write at addr 4799; exactly 4800 writes; `o_short_frame`=0.
5. **Odd byte**: line of 3 bytes 01,02,03 then href fall → one write (0102) at addr 0; next line starts at addr 80 with phase 0.
6. **Continuous**: `i_continuous`=1 for 2 frames, no `i_start` → two `o_frame_done` pulses; second frame restarts at addr 0; `o_busy` stays 1 between frames.
